// File: rtl/regfile_s2_stage_pkg.sv
// Shared pipeline constants for the register-file / S2 stage slice.
//   DATA_W_DEF : default datapath and register width
//   ADDR_W_DEF : default register select width (2^ADDR_W registers)
//   ZERO_REG   : index of the hardwired-zero register
package regfile_s2_stage_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned ZERO_REG   = 0;

endpackage : regfile_s2_stage_pkg

// File: rtl/regfile_s2_stage_core.sv
// Register storage: 2^ADDR_W x DATA_W, one synchronous write port and two
// asynchronous read ports. Register 0 is never written and always reads 0.
//   clk, rst           : clock, asynchronous active-low reset
//   we, waddr, wdata   : write port (ignored for waddr == 0)
//   raddr1/2, rdata1/2_c : combinational read ports
module regfile_core
  import regfile_s2_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1_c,
  output logic [DATA_W-1:0] rdata2_c
);

  localparam int unsigned       NREG     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [NREG];

  // Storage write; writes to the zero register are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != ZERO_SEL)) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous reads with register 0 forced to zero.
  always_comb begin
    rdata1_c = (raddr1 == ZERO_SEL) ? '0 : mem[raddr1];
    rdata2_c = (raddr2 == ZERO_SEL) ? '0 : mem[raddr2];
  end

endmodule : regfile_core

// File: rtl/regfile_s2_stage.sv
// S2 pipeline stage: register-file read with S3 writeback bypass, S2
// pipeline registers with stall/flush control.
//   clk, rst                         : clock, asynchronous active-low reset
//   S1_ReadSelect1/2                 : source register selects from S1
//   S1_WriteSelect/S1_WriteEnable    : destination request carried to S2
//   stall, flush                     : hold S2 / insert bubble (flush wins)
//   S3_WriteData/Select/Enable       : writeback port from S3
//   S2_ReadData1/2                   : registered operands
//   S2_WriteSelect/S2_WriteEnable    : registered destination request
module regfile_s2_stage
  import regfile_s2_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] S1_ReadSelect1,
  input  logic [ADDR_W-1:0] S1_ReadSelect2,
  input  logic [ADDR_W-1:0] S1_WriteSelect,
  input  logic              S1_WriteEnable,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] S3_WriteData,
  input  logic [ADDR_W-1:0] S3_WriteSelect,
  input  logic              S3_WriteEnable,
  output logic [DATA_W-1:0] S2_ReadData1,
  output logic [DATA_W-1:0] S2_ReadData2,
  output logic [ADDR_W-1:0] S2_WriteSelect,
  output logic              S2_WriteEnable
);

  localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] rf_rdata1_c;
  logic [DATA_W-1:0] rf_rdata2_c;
  logic              s3_valid_c;
  logic [DATA_W-1:0] byp1_c;
  logic [DATA_W-1:0] byp2_c;
  logic              hold_upd1_c;
  logic              hold_upd2_c;
  logic [ADDR_W-1:0] S2_ReadSel1;
  logic [ADDR_W-1:0] S2_ReadSel2;

  regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .we       (S3_WriteEnable),
    .waddr    (S3_WriteSelect),
    .wdata    (S3_WriteData),
    .raddr1   (S1_ReadSelect1),
    .raddr2   (S1_ReadSelect2),
    .rdata1_c (rf_rdata1_c),
    .rdata2_c (rf_rdata2_c)
  );

  // Writeback forwarding into fresh reads and into operands held by a stall.
  always_comb begin
    s3_valid_c  = S3_WriteEnable && (S3_WriteSelect != ZERO_SEL);
    byp1_c      = rf_rdata1_c;
    byp2_c      = rf_rdata2_c;
    hold_upd1_c = s3_valid_c && (S3_WriteSelect == S2_ReadSel1);
    hold_upd2_c = s3_valid_c && (S3_WriteSelect == S2_ReadSel2);
    if (s3_valid_c && (S1_ReadSelect1 == S3_WriteSelect)) byp1_c = S3_WriteData;
    if (s3_valid_c && (S1_ReadSelect2 == S3_WriteSelect)) byp2_c = S3_WriteData;
  end

  // S2 pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      S2_ReadData1   <= '0;
      S2_ReadData2   <= '0;
      S2_WriteSelect <= '0;
      S2_WriteEnable <= 1'b0;
      S2_ReadSel1    <= '0;
      S2_ReadSel2    <= '0;
    end else if (flush) begin
      S2_ReadData1   <= '0;
      S2_ReadData2   <= '0;
      S2_WriteSelect <= '0;
      S2_WriteEnable <= 1'b0;
      S2_ReadSel1    <= '0;
      S2_ReadSel2    <= '0;
    end else if (!stall) begin
      S2_ReadData1   <= byp1_c;
      S2_ReadData2   <= byp2_c;
      S2_WriteSelect <= S1_WriteSelect;
      S2_WriteEnable <= S1_WriteEnable;
      S2_ReadSel1    <= S1_ReadSelect1;
      S2_ReadSel2    <= S1_ReadSelect2;
    end else begin
      // Stalled: selects held, operands refreshed if S3 writes their source.
      if (hold_upd1_c) S2_ReadData1 <= S3_WriteData;
      if (hold_upd2_c) S2_ReadData2 <= S3_WriteData;
    end
  end

endmodule : regfile_s2_stage

// File: tb/tb_regfile_s2_stage.sv
// Self-checking bench for regfile_s2_stage: directed scenarios plus a random
// run, all checked through a scoreboard fed by a behavioural model.
module tb_regfile_s2_stage;

  logic        clk;
  logic        rst;
  logic [4:0]  S1_ReadSelect1;
  logic [4:0]  S1_ReadSelect2;
  logic [4:0]  S1_WriteSelect;
  logic        S1_WriteEnable;
  logic        stall;
  logic        flush;
  logic [31:0] S3_WriteData;
  logic [4:0]  S3_WriteSelect;
  logic        S3_WriteEnable;
  logic [31:0] S2_ReadData1;
  logic [31:0] S2_ReadData2;
  logic [4:0]  S2_WriteSelect;
  logic        S2_WriteEnable;

  regfile_s2_stage dut (
    .clk            (clk),
    .rst            (rst),
    .S1_ReadSelect1 (S1_ReadSelect1),
    .S1_ReadSelect2 (S1_ReadSelect2),
    .S1_WriteSelect (S1_WriteSelect),
    .S1_WriteEnable (S1_WriteEnable),
    .stall          (stall),
    .flush          (flush),
    .S3_WriteData   (S3_WriteData),
    .S3_WriteSelect (S3_WriteSelect),
    .S3_WriteEnable (S3_WriteEnable),
    .S2_ReadData1   (S2_ReadData1),
    .S2_ReadData2   (S2_ReadData2),
    .S2_WriteSelect (S2_WriteSelect),
    .S2_WriteEnable (S2_WriteEnable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  ws;
    logic        we;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [31:0] mreg [32];
  logic [31:0] m_rd1, m_rd2;
  logic [4:0]  m_ws, m_rs1, m_rs2;
  logic        m_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    m_rd1 = '0; m_rd2 = '0; m_ws = '0; m_we = 1'b0; m_rs1 = '0; m_rs2 = '0;
  endtask

  function automatic logic [31:0] mbyp(input logic [4:0] s, input logic [31:0] wd,
                                       input logic [4:0] wsel, input logic wen);
    if (s == 5'd0) return 32'd0;
    if (wen && (s == wsel)) return wd;
    return mreg[s];
  endfunction

  // Drive one cycle of stimulus, push the model's expectation, compare after the edge.
  task automatic step(input string tag,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] ws1, input logic we1,
                      input logic st, input logic fl,
                      input logic [31:0] wd, input logic [4:0] wsel, input logic wen);
    exp_t e;
    S1_ReadSelect1 = rs1;
    S1_ReadSelect2 = rs2;
    S1_WriteSelect = ws1;
    S1_WriteEnable = we1;
    stall          = st;
    flush          = fl;
    S3_WriteData   = wd;
    S3_WriteSelect = wsel;
    S3_WriteEnable = wen;
    if (fl) begin
      m_rd1 = '0; m_rd2 = '0; m_ws = '0; m_we = 1'b0; m_rs1 = '0; m_rs2 = '0;
    end else if (!st) begin
      m_rd1 = mbyp(rs1, wd, wsel, wen);
      m_rd2 = mbyp(rs2, wd, wsel, wen);
      m_ws  = ws1;
      m_we  = we1;
      m_rs1 = rs1;
      m_rs2 = rs2;
    end else begin
      if (wen && (wsel != 5'd0) && (wsel == m_rs1)) m_rd1 = wd;
      if (wen && (wsel != 5'd0) && (wsel == m_rs2)) m_rd2 = wd;
    end
    if (wen && (wsel != 5'd0)) mreg[wsel] = wd;
    e.tag = tag; e.rd1 = m_rd1; e.rd2 = m_rd2; e.ws = m_ws; e.we = m_we;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.tag, ".rd1"}, S2_ReadData1, e.rd1);
    chk({e.tag, ".rd2"}, S2_ReadData2, e.rd2);
    chk({e.tag, ".ws"}, 32'(S2_WriteSelect), 32'(e.ws));
    chk({e.tag, ".we"}, 32'(S2_WriteEnable), 32'(e.we));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b0;
    S1_ReadSelect1 = '0; S1_ReadSelect2 = '0; S1_WriteSelect = '0; S1_WriteEnable = 1'b0;
    stall = 1'b0; flush = 1'b0;
    S3_WriteData = '0; S3_WriteSelect = '0; S3_WriteEnable = 1'b0;
    #2;
    chk("rst.rd1", S2_ReadData1, 32'd0);
    chk("rst.rd2", S2_ReadData2, 32'd0);
    chk("rst.ws", 32'(S2_WriteSelect), 32'd0);
    chk("rst.we", 32'(S2_WriteEnable), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Write then read.
    step("w_r5", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 5'd5, 1'b1);
    step("rd_r5", 5'd5, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
    chk("wr_rd.r5", S2_ReadData1, 32'hDEADBEEF);

    // Same-cycle bypass onto both ports.
    step("byp_r7", 5'd7, 5'd7, 5'd1, 1'b0, 1'b0, 1'b0, 32'h12345678, 5'd7, 1'b1);
    chk("byp.p1", S2_ReadData1, 32'h12345678);
    chk("byp.p2", S2_ReadData2, 32'h12345678);

    // Register 0 with and without a simultaneous write.
    step("r0_wr", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 5'd0, 1'b1);
    chk("r0.byp", S2_ReadData1, 32'd0);
    step("r0_rd", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
    chk("r0.rd", S2_ReadData2, 32'd0);

    // Stall with writeback to the held source.
    step("w_r3", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h1, 5'd3, 1'b1);
    step("rd_r3", 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
    chk("stall.pre", S2_ReadData1, 32'h1);
    step("stall_w3", 5'd8, 5'd8, 5'd10, 1'b0, 1'b1, 1'b0, 32'h99, 5'd3, 1'b1);
    chk("stall.rd1", S2_ReadData1, 32'h99);
    chk("stall.rd2", S2_ReadData2, 32'hDEADBEEF);
    chk("stall.ws", 32'(S2_WriteSelect), 32'd4);

    // Flush overrides stall; the S3 write still lands.
    step("flush", 5'd3, 5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 32'h55, 5'd12, 1'b1);
    chk("flush.we", 32'(S2_WriteEnable), 32'd0);
    chk("flush.rd1", S2_ReadData1, 32'd0);
    step("rd_r12", 5'd12, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
    chk("flush.r12", S2_ReadData1, 32'h55);

    // Asynchronous reset between edges.
    step("w_r9", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'hAA, 5'd9, 1'b1);
    step("rd_r9", 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0);
    step("ld_r9", 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
    chk("pre_rst.rd1", S2_ReadData1, 32'hAA);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.rd1", S2_ReadData1, 32'd0);
    chk("arst.rd2", S2_ReadData2, 32'd0);
    chk("arst.ws", 32'(S2_WriteSelect), 32'd0);
    chk("arst.we", 32'(S2_WriteEnable), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step("post_rst_r9", 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
    chk("post_rst.r9", S2_ReadData1, 32'd0);

    // Random traffic over a small register window to exercise bypass paths.
    for (int n = 0; n < 400; n++) begin
      step("rand",
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
           32'($urandom), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_s2_stage
